// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game blocks: colour encoding,
// sequence store depth and the sequence player's state encoding.
package simon_pkg;

    // Colours as stored in the segment store and shown on the LEDs.
    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } colour_t;

    // Deepest sequence the colour store can hold (slot 0 is reserved and never played).
    localparam int MAX_SEQ_LEN = 32;

    // Playback states: show a colour, blank gap, one-cycle completion pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } player_state_t;

endpackage : simon_pkg

// File: rtl/sequence_player_if.sv
// Handshake and data bundle between the game FSM (master) and the
// sequence player (slave). The abort wire exists only when the
// SEQ_PLAYER_ABORT_EN macro is defined.
interface sequence_player_if
    import simon_pkg::*;
#(
    parameter int MAX_LEN = MAX_SEQ_LEN
);
    logic                         start;
    logic [5:0]                   length;
    // Packed store: bits [2i+1:2i] hold slot i; slot 0 is reserved.
    logic [2*(MAX_LEN+1)-1:0]     segment;
    logic [1:0]                   colour;
    logic                         colour_valid;
    logic                         busy;
    logic                         done;
`ifdef SEQ_PLAYER_ABORT_EN
    logic                         abort;

    modport master (
        output start, length, segment, abort,
        input  colour, colour_valid, busy, done
    );

    modport slave (
        input  start, length, segment, abort,
        output colour, colour_valid, busy, done
    );
`else
    modport master (
        output start, length, segment,
        input  colour, colour_valid, busy, done
    );

    modport slave (
        input  start, length, segment,
        output colour, colour_valid, busy, done
    );
`endif

endinterface : sequence_player_if

// File: rtl/sequence_player_timer.sv
// phase_timer: loadable down-counter that stops at zero. expired_o is
// high whenever the count is zero. Shared with the input-timeout logic.
module phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: reload wins, otherwise count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule : phase_timer

// File: rtl/sequence_player.sv
// sequence_player: replays the stored colour sequence from the oldest
// slot (length) down to the newest (slot 1), each colour shown for
// ON_CYCLES followed by an OFF_CYCLES blank gap, then pulses done.
// Optional macro SEQ_PLAYER_ABORT_EN adds an abort input that drops
// back to IDLE from ON/OFF without a done pulse.
module sequence_player
    import simon_pkg::*;
#(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int MAX_LEN    = MAX_SEQ_LEN
) (
    input  logic               clk,
    input  logic               reset,
    sequence_player_if.slave   seg
);

    localparam int TMR_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int IDX_W   = $clog2(MAX_LEN + 1);

    localparam logic [TMR_W-1:0] ON_RELOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_RELOAD = TMR_W'(OFF_CYCLES - 1);

    player_state_t    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    colour_t          colour_q, colour_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_expired;

    logic [IDX_W-1:0] len_c;
    logic [1:0]       slot [1:MAX_LEN];
    logic             unused_slot0;

    // Unpack the live colour store; slot 0 is reserved and never played.
    for (genvar i = 1; i <= MAX_LEN; i++) begin : g_slot
        assign slot[i] = seg.segment[2*i +: 2];
    end
    assign unused_slot0 = ^seg.segment[1:0];

    // Requested lengths beyond the store depth play the whole store.
    assign len_c = (int'(seg.length) > MAX_LEN) ? IDX_W'(MAX_LEN) : IDX_W'(seg.length);

    phase_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .load_i       (tmr_load),
        .load_value_i (tmr_value),
        .expired_o    (tmr_expired)
    );

    // Next-state logic: walk slots oldest to newest with ON/OFF timing.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        colour_d  = colour_q;
        tmr_load  = 1'b0;
        tmr_value = ON_RELOAD;

        unique case (state_q)
            IDLE: begin
                if (seg.start) begin
                    if (len_c != '0) begin
                        idx_d    = len_c;
                        colour_d = colour_t'(slot[len_c]);
                        tmr_load = 1'b1;
                        state_d  = ON;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            ON: begin
                if (tmr_expired) begin
                    tmr_load  = 1'b1;
                    tmr_value = OFF_RELOAD;
                    state_d   = OFF;
                end
            end
            OFF: begin
                if (tmr_expired) begin
                    if (idx_q == IDX_W'(1)) begin
                        state_d  = DONE;
                    end else begin
                        idx_d    = idx_q - 1'b1;
                        colour_d = colour_t'(slot[idx_q - 1'b1]);
                        tmr_load = 1'b1;
                        state_d  = ON;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef SEQ_PLAYER_ABORT_EN
        // Abort overrides any timer expiry seen in the same cycle.
        if (seg.abort && (state_q == ON || state_q == OFF)) begin
            state_d  = IDLE;
            idx_d    = idx_q;
            colour_d = colour_q;
            tmr_load = 1'b0;
        end
`endif
    end

    // State, slot index and displayed colour registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            colour_q <= RED;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            colour_q <= colour_d;
        end
    end

    assign seg.colour       = colour_q;
    assign seg.colour_valid = (state_q == ON);
    assign seg.busy         = (state_q == ON) || (state_q == OFF);
    assign seg.done         = (state_q == DONE);

endmodule : sequence_player

// File: tb/tb_sequence_player.sv
// Testbench for sequence_player with ON=4, OFF=2, MAX_LEN=32. Expected
// outputs come from a cycle-index model: cycle k after the start edge
// lies in slot (k-1)/period at phase (k-1)%period. Build with
// SEQ_PLAYER_ABORT_EN defined to also exercise abort.
module tb_sequence_player;
    import simon_pkg::*;

    localparam int ON      = 4;
    localparam int OFF     = 2;
    localparam int PERIOD  = ON + OFF;
    localparam int MAX_LEN = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sequence_player_if #(.MAX_LEN(MAX_LEN)) bus ();

    sequence_player #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .MAX_LEN    (MAX_LEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .seg   (bus)
    );

    int total = 0;
    int bad   = 0;
    int seg_m [0:MAX_LEN];
    int model_colour = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int ec, input int ev,
                                 input int eb, input int ed);
        check({tag, " colour"}, 32'(bus.colour), ec);
        check({tag, " valid"},  32'(bus.colour_valid), ev);
        check({tag, " busy"},   32'(bus.busy), eb);
        check({tag, " done"},   32'(bus.done), ed);
    endtask

    task automatic randomize_store();
        for (int i = 0; i <= MAX_LEN; i++) seg_m[i] = int'($urandom_range(0, 3));
    endtask

    task automatic pack_store();
        for (int i = 0; i <= MAX_LEN; i++) bus.segment[2*i +: 2] = 2'(seg_m[i]);
    endtask

    // Start a playback at the current negedge and check every cycle until
    // a few cycles past the expected done pulse. Optional events at cycle k:
    // re-pulse start, change length, abort, or assert reset.
    task automatic play(input int len, input int re_k, input int chg_k, input int chg_len,
                        input int abort_k, input int reset_k);
        int l, busy_cycles, last_k, ec, ev, eb, ed;
        l           = (len > MAX_LEN) ? MAX_LEN : len;
        busy_cycles = l * PERIOD;
        last_k      = busy_cycles + 3;
        bus.length  = 6'(len);
        bus.start   = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= last_k; k++) begin
            if (abort_k > 0 && k > abort_k) begin
                ec = model_colour; ev = 0; eb = 0; ed = 0;
            end else if (k <= busy_cycles) begin
                ec = seg_m[l - (k - 1) / PERIOD];
                model_colour = ec;
                ev = (((k - 1) % PERIOD) < ON) ? 1 : 0;
                eb = 1;
                ed = 0;
            end else begin
                ec = model_colour; ev = 0; eb = 0;
                ed = (k == busy_cycles + 1) ? 1 : 0;
            end
            check_outputs($sformatf("L%0d k%0d", len, k), ec, ev, eb, ed);

            if (k == reset_k) begin
                bus.start = 1'b0;
                #2 reset = 1'b1;
                #1 model_colour = 0;
                check_outputs($sformatf("async reset k%0d", k), 0, 0, 0, 0);
                @(negedge clk);
                check_outputs("held in reset", 0, 0, 0, 0);
                reset = 1'b0;
                return;
            end

            bus.start = (k == re_k);
            if (k == chg_k) bus.length = 6'(chg_len);
`ifdef SEQ_PLAYER_ABORT_EN
            bus.abort = (k == abort_k);
`endif
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int len, gap;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.length  = '0;
        bus.segment = '0;
`ifdef SEQ_PLAYER_ABORT_EN
        bus.abort   = 1'b0;
`endif
        #1;
        check_outputs("reset state", 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_outputs("after reset", 0, 0, 0, 0);

        // Directed L=3 sequence: colours 2, 1, 3.
        randomize_store();
        seg_m[3] = 2; seg_m[2] = 1; seg_m[1] = 3;
        pack_store();
        play(3, 0, 0, 0, 0, 0);

        // Empty sequence: done next cycle, never busy.
        play(0, 0, 0, 0, 0, 0);

        // Over-length request clamps to the full store.
        randomize_store();
        seg_m[32] = 1;
        pack_store();
        play(40, 0, 0, 0, 0, 0);

        // Start re-pulsed mid-playback and length changed: both ignored.
        randomize_store();
        pack_store();
        play(3, 5, 2, 1, 0, 0);

        // Start during the done cycle is ignored.
        play(2, 2 * PERIOD + 1, 0, 0, 0, 0);

        // Reset mid-playback, then a clean playback.
        play(3, 0, 0, 0, 0, 8);
        check_outputs("idle after reset", 0, 0, 0, 0);
        randomize_store();
        pack_store();
        play(4, 0, 0, 0, 0, 0);

`ifdef SEQ_PLAYER_ABORT_EN
        // Abort in the first gap: busy drops next cycle, no done.
        play(3, 0, 0, 0, 6, 0);
        bus.abort = 1'b0;
        play(1, 0, 0, 0, 0, 0);
`endif

        // Randomised lengths and stores with idle gaps between runs.
        for (int n = 0; n < 8; n++) begin
            randomize_store();
            pack_store();
            len = int'($urandom_range(0, 9));
            play(len, 0, 0, 0, 0, 0);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                check_outputs($sformatf("idle gap %0d", n), model_colour, 0, 0, 0);
                @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sequence_player
